i2s_tx: RTL and testbench

- Master-mode I2S transmitter, the output-side counterpart of the I2S capture path.
- Accepts stereo sample pairs on a valid/ready handshake in the iSysClk domain.
- Generates oBCK and oLRCK from iSysClk by division and serializes each channel MSB-first on oSD in standard I2S framing: one-BCK delay after each LRCK edge, LRCK low = left.
- Feeds an external DAC/codec; everything runs on one clock, and BCK is a divided data output, not a clock.

---
 rtl/i2s_tx.sv | 123 ++++++++++++
 tb/tb_i2s_tx.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx.sv
// Master-mode I2S transmitter: divides the system clock into BCK/LRCK and serializes
// buffered stereo pairs MSB-first on SD. Optional underrun counter via I2S_TX_UNDERRUN_CNT_EN.
module i2s_tx #(
  parameter int DATA_W  = 24,
  parameter int SLOT_W  = 32,
  parameter int BCK_DIV = 4
) (
  input  logic                     iSysClk,
  input  logic                     iRstN,
  input  logic signed [DATA_W-1:0] iDataL,
  input  logic signed [DATA_W-1:0] iDataR,
  input  logic                     iValid,
  output logic                     oReady,
  output logic                     oBCK,
  output logic                     oLRCK,
  output logic                     oSD,
`ifdef I2S_TX_UNDERRUN_CNT_EN
  input  logic                     iCntClr,
  output logic [7:0]               oUnderrunCnt,
`endif
  output logic                     oUnderrun
);

  localparam int DW = $clog2(BCK_DIV);
  localparam int BW = $clog2(2 * SLOT_W);

  logic [DW-1:0] div_cnt;
  logic          div_tc;
  logic          fall;
  logic [BW-1:0] b;
  logic [BW-1:0] p;
  logic          in_right;
  logic          frame_start;
  logic          full;
  logic          sd_next;
  logic signed [DATA_W-1:0] hold_l, hold_r;
  logic signed [DATA_W-1:0] work_l, work_r;

  assign div_tc      = (div_cnt == DW'(BCK_DIV - 1));
  assign fall        = div_tc & oBCK;
  assign in_right    = (b >= BW'(SLOT_W));
  assign p           = in_right ? (b - BW'(SLOT_W)) : b;
  assign frame_start = fall && (b == '0);
  assign oReady      = ~full;

  // Slot position 1 carries the MSB so it lands one BCK after the LRCK edge.
  always_comb begin
    sd_next = 1'b0;
    for (int i = 1; i <= DATA_W; i++) begin
      if (p == BW'(i)) sd_next = in_right ? work_r[DATA_W-i] : work_l[DATA_W-i];
    end
  end

  always_ff @(posedge iSysClk or negedge iRstN) begin
    if (!iRstN) begin
      div_cnt <= '0;
      oBCK    <= 1'b0;
      b       <= '0;
      oLRCK   <= 1'b1;
      oSD     <= 1'b0;
    end else begin
      if (div_tc) begin
        div_cnt <= '0;
        oBCK    <= ~oBCK;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      if (fall) begin
        b     <= (b == BW'(2 * SLOT_W - 1)) ? '0 : b + 1'b1;
        oLRCK <= in_right;
        oSD   <= sd_next;
      end
    end
  end

  // Load and acceptance are exclusive: one needs the buffer full, the other empty.
  always_ff @(posedge iSysClk or negedge iRstN) begin
    if (!iRstN) begin
      full      <= 1'b0;
      oUnderrun <= 1'b0;
      hold_l    <= '0;
      hold_r    <= '0;
      work_l    <= '0;
      work_r    <= '0;
    end else begin
      oUnderrun <= 1'b0;
      if (frame_start) begin
        if (full) begin
          work_l <= hold_l;
          work_r <= hold_r;
          full   <= 1'b0;
        end else begin
          work_l    <= '0;
          work_r    <= '0;
          oUnderrun <= 1'b1;
        end
      end
      if (iValid && !full) begin
        hold_l <= iDataL;
        hold_r <= iDataR;
        full   <= 1'b1;
      end
    end
  end

`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [7:0] ur_cnt;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // A clear coinciding with a pulse keeps that pulse, leaving a count of one.
  always_ff @(posedge iSysClk or negedge iRstN) begin
    if (!iRstN)           ur_cnt <= 8'd0;
    else if (iCntClr)     ur_cnt <= {7'd0, oUnderrun};
    else if (oUnderrun)   ur_cnt <= sat_inc(ur_cnt);
  end

  assign oUnderrunCnt = ur_cnt;
`endif

endmodule

// File: tb/tb_i2s_tx.sv
// Scoreboard bench for i2s_tx: frame-level reference model feeds an expected-frame
// queue; a deserializing monitor reassembles frames from BCK/LRCK/SD and compares.
module tb_i2s_tx;
  localparam int DATA_W  = 24;
  localparam int SLOT_W  = 32;
  localparam int BCK_DIV = 4;
  localparam int FRAME   = 4 * SLOT_W * BCK_DIV;
  localparam int FIRST   = 2 * BCK_DIV;
  localparam int NBITS   = 2 * SLOT_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [DATA_W-1:0] dl = '0, dr = '0;
  logic valid = 1'b0;
  logic ready, bck, lrck, sd, ur;
`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic clr = 1'b0;
  logic [7:0] ucnt;
  int m_cnt = 0;
`endif

  i2s_tx #(.DATA_W(DATA_W), .SLOT_W(SLOT_W), .BCK_DIV(BCK_DIV)) dut (
    .iSysClk(clk), .iRstN(rst_n), .iDataL(dl), .iDataR(dr), .iValid(valid),
    .oReady(ready), .oBCK(bck), .oLRCK(lrck), .oSD(sd),
`ifdef I2S_TX_UNDERRUN_CNT_EN
    .iCntClr(clr), .oUnderrunCnt(ucnt),
`endif
    .oUnderrun(ur)
  );

  always #5 clk = ~clk;

  typedef struct { logic [DATA_W-1:0] l; logic [DATA_W-1:0] r; bit ur; } frame_t;
  frame_t exp_q[$];

  int checks = 0;
  int fails = 0;
  int frames_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  // Reference model: edges since reset release, one-entry buffer, frame loads every FRAME cycles.
  int n = 0;
  bit m_full = 0;
  bit m_ur = 0;
  logic [DATA_W-1:0] m_l = '0, m_r = '0;
  bit full_pre, load, ur_prev;

  always @(posedge clk) begin
    ur_prev = m_ur;
    if (!rst_n) begin
      n = 0;
      m_full = 0;
      m_ur = 0;
`ifdef I2S_TX_UNDERRUN_CNT_EN
      m_cnt = 0;
`endif
    end else begin
      n++;
      load = (n >= FIRST) && (((n - FIRST) % FRAME) == 0);
      full_pre = m_full;
      m_ur = 0;
      if (load) begin
        if (full_pre) begin
          exp_q.push_back('{m_l, m_r, 1'b0});
          m_full = 0;
        end else begin
          exp_q.push_back('{'0, '0, 1'b1});
          m_ur = 1;
        end
      end
      if (!full_pre && valid) begin
        m_full = 1;
        m_l = dl;
        m_r = dr;
      end
`ifdef I2S_TX_UNDERRUN_CNT_EN
      if (clr) m_cnt = ur_prev ? 1 : 0;
      else if (ur_prev && m_cnt < 255) m_cnt++;
`endif
    end
    #1;
    chk("bck", bck, ((n / BCK_DIV) % 2));
    chk("lrck", lrck, (n < FIRST) ? 1 : (((n - FIRST) / (FRAME / 2)) % 2));
    chk("ready", ready, !m_full);
    chk("underrun", ur, m_ur);
`ifdef I2S_TX_UNDERRUN_CNT_EN
    chk("underrun_cnt", ucnt, m_cnt);
`endif
  end

  // Monitor: samples SD and LRCK on each BCK rise, like a receiving codec.
  bit prev_bck = 0;
  bit ur_seen = 0;
  bit frame_ur = 0;
  int idx = 0;
  logic bits [NBITS];
  logic lrs [NBITS];

  task automatic check_frame();
    frame_t e;
    logic [DATA_W-1:0] l, r;
    logic pad, lr_err;
    pad = 1'b0;
    lr_err = 1'b0;
    for (int k = 0; k < DATA_W; k++) begin
      l[DATA_W-1-k] = bits[1 + k];
      r[DATA_W-1-k] = bits[SLOT_W + 1 + k];
    end
    for (int i = 0; i < NBITS; i++) begin
      if ((i % SLOT_W) == 0 || (i % SLOT_W) > DATA_W) pad = pad | bits[i];
      if (lrs[i] !== ((i >= SLOT_W) ? 1'b1 : 1'b0)) lr_err = 1'b1;
    end
    frames_done++;
    if (exp_q.size() == 0) begin
      checks++;
      fails++;
      $display("FAIL frame_unexpected at %0t: got frame L=%0h R=%0h, expected none", $time, l, r);
    end else begin
      e = exp_q.pop_front();
      chk("frame_left", l, e.l);
      chk("frame_right", r, e.r);
      chk("frame_underrun", frame_ur, e.ur);
      chk("frame_padding", pad, 0);
      chk("frame_lrck_pattern", lr_err, 0);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      idx = 0;
      ur_seen = 0;
      prev_bck = 0;
    end else begin
      if (ur) ur_seen = 1;
      if (bck && !prev_bck) begin
        if (idx == 0 && lrck == 1'b0) begin
          frame_ur = ur_seen;
          ur_seen = 0;
        end
        if (idx > 0 || lrck == 1'b0) begin
          bits[idx] = sd;
          lrs[idx] = lrck;
          idx++;
        end
        if (idx == NBITS) begin
          check_frame();
          idx = 0;
        end
      end
      prev_bck = bck;
    end
  end

  task automatic send(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r, input bit hold);
    int t = 0;
    @(negedge clk);
    valid = 1'b1;
    dl = l;
    dr = r;
    while (!ready && t < 2 * FRAME) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2 * FRAME) begin
      checks++;
      fails++;
      $display("FAIL send_timeout at %0t: ready stayed %0b, expected 1", $time, ready);
    end
    @(posedge clk);
    if (!hold) begin
      @(negedge clk);
      valid = 1'b0;
    end
  endtask

  task automatic wait_pos(input int pos);
    int t = 0;
    @(negedge clk);
    while (!(n >= FIRST && ((n - FIRST) % FRAME) == pos) && t < 2 * FRAME) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2 * FRAME) begin
      checks++;
      fails++;
      $display("FAIL wait_pos_timeout at %0t: position %0d, expected %0d", $time, (n - FIRST) % FRAME, pos);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_bck", bck, 0);
    chk("reset_lrck", lrck, 1);
    chk("reset_sd", sd, 0);
    chk("reset_ready", ready, 1);
    chk("reset_underrun", ur, 0);
    rst_n = 1'b1;

    // Idle: three underrun frames.
    repeat (1100) @(negedge clk);

    send(24'hA5C3F0, 24'h123456, 1'b0);
    repeat (FRAME + 100) @(negedge clk);

    // Back-to-back stream with valid held high.
    for (int i = 0; i < 4; i++) send(24'($urandom), 24'($urandom), 1'b1);
    @(negedge clk);
    valid = 1'b0;

    // Late arrival inside an underrun frame.
    repeat (2 * FRAME) @(negedge clk);
    wait_pos(150);
    send(24'($urandom), 24'($urandom), 1'b0);
    repeat (FRAME) @(negedge clk);

    // Reset at b=40 with a pair buffered.
    wait_pos(16);
    send(24'h7FFFFF, 24'h800001, 1'b0);
    wait_pos(40 * 2 * BCK_DIV);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("midreset_bck", bck, 0);
    chk("midreset_lrck", lrck, 1);
    chk("midreset_sd", sd, 0);
    chk("midreset_ready", ready, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * FRAME) @(negedge clk);

    // Randomized traffic with random gaps.
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 700)) @(negedge clk);
      send(24'($urandom), 24'($urandom), 1'b0);
    end

`ifdef I2S_TX_UNDERRUN_CNT_EN
    repeat (2 * FRAME) @(negedge clk);
    begin
      int t = 0;
      while (!m_ur && t < 2 * FRAME) begin
        @(negedge clk);
        t++;
      end
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("cnt_clear_coincide", ucnt, 1);
    end
`endif

    repeat (2 * FRAME) @(negedge clk);
    chk("queue_drained", (exp_q.size() <= 1), 1);
    chk("frames_seen", (frames_done >= 12), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
